// File: rtl/rst_source.sv
// rst_source: always-on reset request generator.
// Merges power-on, a debounced external button, a software request and an
// internal watchdog into one stretched, registered active-low reset, and
// keeps a sticky record of which source caused the last reset. Only rst_ib
// resets this block, so the cause record survives the resets it generates.
//
// state | meaning
// ------+------------------------------------------------------------------
// HOLD  | rst_ob low; hold timer counts down the minimum reset window
// RUN   | rst_ob high; any request returns to HOLD with a fresh window
module rst_source #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 32,
    parameter int WDT_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 rst_ib,
    input  logic                 btn_ib,
    input  logic                 sw_rst_req,
    input  logic                 wdt_en,
    input  logic                 wdt_kick,
    input  logic [WDT_WIDTH-1:0] wdt_limit,
    input  logic                 cause_clr,
    output logic                 rst_ob,
    output logic [3:0]           cause
);

    localparam int DB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    // Timers load (N-1) and fire when they reach zero, so a window of N
    // cycles is measured with a single terminal-count compare.
    localparam logic [DB_W-1:0]   DB_LOAD   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    logic                 r_btn_meta;
    logic                 r_btn_sync;
    logic                 r_btn_db;
    logic [DB_W-1:0]      r_db_cnt;

    logic [WDT_WIDTH-1:0] r_wdt_cnt;
    logic                 w_wdt_active;
    logic                 w_wdt_expire;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [HOLD_W-1:0]    r_hold_cnt;
    logic [HOLD_W-1:0]    w_hold_nxt;
    logic                 r_rst_ob;

    logic                 w_btn_req;
    logic                 w_req;
    logic [3:0]           w_cause_set;
    logic [3:0]           r_cause;

    // Two-flop synchronizer for the asynchronous, active-low button.
    always_ff @(posedge clk or negedge rst_ib) begin
        if (!rst_ib) begin
            r_btn_meta <= 1'b1;
            r_btn_sync <= 1'b1;
        end else begin
            r_btn_meta <= btn_ib;
            r_btn_sync <= r_btn_meta;
        end
    end

    // Debouncer: a new level is accepted only after it has been stable for
    // DEBOUNCE_CYCLES consecutive synced cycles; any return to the current
    // level restarts the window.
    always_ff @(posedge clk or negedge rst_ib) begin
        if (!rst_ib) begin
            r_btn_db <= 1'b1;
            r_db_cnt <= DB_LOAD;
        end else if (r_btn_sync == r_btn_db) begin
            r_db_cnt <= DB_LOAD;
        end else if (r_db_cnt == '0) begin
            r_btn_db <= r_btn_sync;
            r_db_cnt <= DB_LOAD;
        end else begin
            r_db_cnt <= r_db_cnt - DB_W'(1);
        end
    end

    // The watchdog compares against the live limit, so it counts up; a
    // limit of zero or a cleared enable parks it at zero.
    assign w_wdt_active = wdt_en && (wdt_limit != '0);
    assign w_wdt_expire = (r_state == ST_RUN) && w_wdt_active && !wdt_kick
                          && (r_wdt_cnt == wdt_limit);

    // Watchdog counter: runs only in RUN; a kick wins over expiry.
    always_ff @(posedge clk or negedge rst_ib) begin
        if (!rst_ib) begin
            r_wdt_cnt <= '0;
        end else if ((r_state == ST_HOLD) || !w_wdt_active || wdt_kick) begin
            r_wdt_cnt <= '0;
        end else begin
            r_wdt_cnt <= r_wdt_cnt + WDT_WIDTH'(1);
        end
    end

    // A held-low button keeps the request asserted for as long as it is held.
    assign w_btn_req = !r_btn_db;
    assign w_req     = w_btn_req || sw_rst_req || w_wdt_expire;

    // State register; rst_ob is registered from the next state so it moves
    // on the same edge as the FSM and never glitches.
    always_ff @(posedge clk or negedge rst_ib) begin
        if (!rst_ib) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= HOLD_LOAD;
            r_rst_ob   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_rst_ob   <= (w_state_nxt == ST_RUN);
        end
    end

    // Next state: any request in HOLD restarts the full hold window.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        case (r_state)
            ST_HOLD: begin
                if (w_req) begin
                    w_hold_nxt = HOLD_LOAD;
                end else if (r_hold_cnt == '0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_hold_nxt = r_hold_cnt - HOLD_W'(1);
                end
            end
            ST_RUN: begin
                if (w_req) begin
                    w_state_nxt = ST_HOLD;
                    w_hold_nxt  = HOLD_LOAD;
                end
            end
        endcase
    end

    // Sticky cause flags {wdt, sw, btn, por}; a set beats a clear on the
    // same edge, and por is only ever set by rst_ib.
    assign w_cause_set = {w_wdt_expire, sw_rst_req, w_btn_req, 1'b0};

    always_ff @(posedge clk or negedge rst_ib) begin
        if (!rst_ib) begin
            r_cause <= 4'b0001;
        end else begin
            r_cause <= w_cause_set | (r_cause & {4{!cause_clr}});
        end
    end

    assign rst_ob = r_rst_ob;
    assign cause  = r_cause;

endmodule
